// File: rtl/pr_bus_pkg.sv
// Shared definitions for the processor-side device bus: address map, word size,
// device bases and the copy-master state encoding.
package pr_bus_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [ADDR_W-1:0] MAP_LO_DEF = 32'h0000_7F00;
  localparam logic [ADDR_W-1:0] MAP_HI_DEF = 32'h0000_7F43;

  localparam logic [ADDR_W-1:0] TIMER_BASE  = 32'h0000_7F00;
  localparam logic [ADDR_W-1:0] UART_BASE   = 32'h0000_7F10;
  localparam logic [ADDR_W-1:0] SWITCH_BASE = 32'h0000_7F2C;
  localparam logic [ADDR_W-1:0] LED_BASE    = 32'h0000_7F34;
  localparam logic [ADDR_W-1:0] TUBE_BASE   = 32'h0000_7F38;
  localparam logic [ADDR_W-1:0] KEY_BASE    = 32'h0000_7F40;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } state_e;

endpackage

// File: rtl/pr_copy_master_if.sv
// Device-bus signals plus arbiter handshake, seen from initiator and responder.
interface pr_copy_master_if;
  import pr_bus_pkg::*;

  logic              bus_req;
  logic              bus_gnt;
  logic [ADDR_W-1:0] pr_addr;
  logic              pr_we;
  logic [DATA_W-1:0] pr_wd;
  logic [DATA_W-1:0] pr_rd;

  modport master (
    output bus_req, pr_addr, pr_we, pr_wd,
    input  bus_gnt, pr_rd
  );

  modport slave (
    input  bus_req, pr_addr, pr_we, pr_wd,
    output bus_gnt, pr_rd
  );

endinterface

// File: rtl/pr_range_chk.sv
// Combinational legality check of one device word address against the map window.
module pr_range_chk
  import pr_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MAP_LO = MAP_LO_DEF,
  parameter logic [ADDR_W-1:0] MAP_HI = MAP_HI_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              ok
);

  // The whole word must fit below MAP_HI, so the last legal start is MAP_HI-3.
  assign ok = (addr >= MAP_LO) &&
              (addr <= (MAP_HI - ADDR_W'(WORD_BYTES - 1))) &&
              (addr[1:0] == 2'b00);

endmodule

// File: rtl/pr_copy_master.sv
// Device-bus copy engine: moves COUNT words src->dst as atomic read/write pairs
// under an external arbiter and raises a level interrupt on completion.
module pr_copy_master
  import pr_bus_pkg::*;
#(
  parameter int unsigned       COUNT_W = 8,
  parameter logic [ADDR_W-1:0] MAP_LO  = MAP_LO_DEF,
  parameter logic [ADDR_W-1:0] MAP_HI  = MAP_HI_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  src_addr,
  input  logic [ADDR_W-1:0]  dst_addr,
  input  logic [COUNT_W-1:0] count,
  input  logic               src_inc,
  input  logic               dst_inc,
  input  logic               abort,
  input  logic               irq_ack,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               aborted,
  output logic               irq,
  pr_copy_master_if.master   bus
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  src_q, src_d, dst_q, dst_d;
  logic [ADDR_W-1:0]  src_nxt, dst_nxt;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic               src_inc_q, src_inc_d, dst_inc_q, dst_inc_d;
  logic               abort_pend_q, abort_pend_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               err_q, err_d, aborted_q, aborted_d, irq_q, irq_d;
  logic               bus_req_q, bus_req_d, pr_we_q, pr_we_d;
  logic [ADDR_W-1:0]  pr_addr_q, pr_addr_d;
  logic [DATA_W-1:0]  pr_wd_q, pr_wd_d;
  logic               src_ok, dst_ok, irq_clr;

  // Addresses as they will be after the current cycle's post-write increment.
  assign src_nxt = (state_q == WR && src_inc_q) ? src_q + ADDR_W'(WORD_BYTES) : src_q;
  assign dst_nxt = (state_q == WR && dst_inc_q) ? dst_q + ADDR_W'(WORD_BYTES) : dst_q;

  pr_range_chk #(.MAP_LO(MAP_LO), .MAP_HI(MAP_HI)) u_src_chk (.addr(src_nxt), .ok(src_ok));
  pr_range_chk #(.MAP_LO(MAP_LO), .MAP_HI(MAP_HI)) u_dst_chk (.addr(dst_nxt), .ok(dst_ok));

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    data_d       = data_q;
    rem_d        = rem_q;
    src_inc_d    = src_inc_q;
    dst_inc_d    = dst_inc_q;
    abort_pend_d = abort_pend_q;
    err_d        = err_q;
    aborted_d    = aborted_q;
    irq_d        = irq_q;
    irq_clr      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d        = src_addr;
          dst_d        = dst_addr;
          rem_d        = count;
          src_inc_d    = src_inc;
          dst_inc_d    = dst_inc;
          err_d        = 1'b0;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
          irq_clr      = 1'b1;
          state_d      = (count == '0) ? FIN : REQ;
        end
      end
      REQ: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = FIN;
        end else if (bus.bus_gnt) begin
          if (src_ok && dst_ok) begin
            state_d = RD;
          end else begin
            err_d   = 1'b1;
            state_d = FIN;
          end
        end
      end
      RD: begin
        // Abort seen mid-pair is deferred until the word's write has gone out.
        data_d       = bus.pr_rd;
        abort_pend_d = abort_pend_q | abort;
        state_d      = WR;
      end
      WR: begin
        src_d        = src_nxt;
        dst_d        = dst_nxt;
        rem_d        = rem_q - COUNT_W'(1);
        abort_pend_d = 1'b0;
        if (rem_q == COUNT_W'(1)) begin
          state_d = FIN;
        end else if (abort || abort_pend_q) begin
          aborted_d = 1'b1;
          state_d   = FIN;
        end else if (bus.bus_gnt) begin
          if (src_ok && dst_ok) begin
            state_d = RD;
          end else begin
            err_d   = 1'b1;
            state_d = FIN;
          end
        end else begin
          state_d = REQ;
        end
      end
      FIN: begin
        abort_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Completion beats a coincident acknowledge.
    if (irq_clr || irq_ack) irq_d = 1'b0;
    if (state_q == FIN)     irq_d = 1'b1;

    busy_d    = (state_d != IDLE);
    done_d    = (state_d == FIN);
    bus_req_d = (state_d == REQ) || (state_d == RD) || (state_d == WR);
    pr_we_d   = (state_d == WR);
    pr_addr_d = pr_addr_q;
    pr_wd_d   = pr_wd_q;
    if (state_d == RD) pr_addr_d = src_d;
    if (state_d == WR) begin
      pr_addr_d = dst_d;
      pr_wd_d   = data_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      data_q       <= '0;
      rem_q        <= '0;
      src_inc_q    <= 1'b0;
      dst_inc_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      aborted_q    <= 1'b0;
      irq_q        <= 1'b0;
      bus_req_q    <= 1'b0;
      pr_we_q      <= 1'b0;
      pr_addr_q    <= '0;
      pr_wd_q      <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      data_q       <= data_d;
      rem_q        <= rem_d;
      src_inc_q    <= src_inc_d;
      dst_inc_q    <= dst_inc_d;
      abort_pend_q <= abort_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      aborted_q    <= aborted_d;
      irq_q        <= irq_d;
      bus_req_q    <= bus_req_d;
      pr_we_q      <= pr_we_d;
      pr_addr_q    <= pr_addr_d;
      pr_wd_q      <= pr_wd_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign aborted     = aborted_q;
  assign irq         = irq_q;
  assign bus.bus_req = bus_req_q;
  assign bus.pr_we   = pr_we_q;
  assign bus.pr_addr = pr_addr_q;
  assign bus.pr_wd   = pr_wd_q;

endmodule

// File: tb/tb_pr_copy_master.sv
// Directed bench for pr_copy_master with a small device-memory responder.
module tb_pr_copy_master;

  logic        clk = 1'b0;
  logic        rst_n, start, src_inc, dst_inc, abort, irq_ack;
  logic [31:0] src_addr, dst_addr;
  logic [7:0]  count;
  logic        busy, done, err, aborted, irq;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  bit req_seen;
  logic [31:0] waddr[$];
  logic [31:0] wdata[$];
  logic [31:0] mem [0:255];

  pr_copy_master_if bus_if ();

  pr_copy_master #(.COUNT_W(8), .MAP_LO(32'h7F00), .MAP_HI(32'h7F43)) dut (
    .clk(clk), .reset(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .count(count), .src_inc(src_inc), .dst_inc(dst_inc), .abort(abort), .irq_ack(irq_ack),
    .busy(busy), .done(done), .err(err), .aborted(aborted), .irq(irq), .bus(bus_if)
  );

  always #5 clk = ~clk;

  assign bus_if.pr_rd = mem[bus_if.pr_addr[9:2]];

  always @(negedge clk) begin
    if (bus_if.bus_req) req_seen = 1'b1;
    if (bus_if.pr_we) begin
      waddr.push_back(bus_if.pr_addr);
      wdata.push_back(bus_if.pr_wd);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    waddr.delete();
    wdata.delete();
    req_seen = 1'b0;
  endtask

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n,
                            input logic si, input logic di);
    src_addr = s; dst_addr = d; count = n; src_inc = si; dst_inc = di;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done();
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic check_write(input string tag, input int i, input logic [31:0] a, input logic [31:0] dv);
    if (i < waddr.size()) begin
      check({tag, "_addr"}, waddr[i], a);
      check({tag, "_data"}, wdata[i], dv);
    end else begin
      check({tag, "_missing"}, 32'(waddr.size()), 32'(i + 1));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; src_inc = 1'b0; dst_inc = 1'b0; abort = 1'b0; irq_ack = 1'b0;
    src_addr = '0; dst_addr = '0; count = '0;
    bus_if.bus_gnt = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    mem[8'hC0] = 32'hA0A0_0001;
    mem[8'hC1] = 32'hA0A0_0002;
    mem[8'hCB] = 32'h1111_1111;
    mem[8'hCC] = 32'h2222_2222;
    mem[8'hCD] = 32'h3333_3333;

    tick(); tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_req", 32'(bus_if.bus_req), 0);
    check("rst_we", 32'(bus_if.pr_we), 0);
    check("rst_addr", bus_if.pr_addr, 0);
    check("rst_wd", bus_if.pr_wd, 0);
    rst_n = 1'b1;
    tick();

    // Three incrementing words, grant held.
    clear_log();
    start_copy(32'h7F2C, 32'h7F38, 8'd3, 1'b1, 1'b1);
    wait_done();
    check("t1_cycles", 32'(cyc), 32'd8);
    check("t1_err", 32'(err), 0);
    check("t1_irq_fin", 32'(irq), 0);
    check("t1_nwr", 32'(waddr.size()), 32'd3);
    check_write("t1_w0", 0, 32'h7F38, 32'h1111_1111);
    check_write("t1_w1", 1, 32'h7F3C, 32'h2222_2222);
    check_write("t1_w2", 2, 32'h7F40, 32'h3333_3333);
    tick();
    check("t1_irq", 32'(irq), 1);
    check("t1_busy", 32'(busy), 0);

    // Fixed addresses, grant dropped for three cycles after each of the first three writes.
    clear_log();
    begin
      int nwr = 0;
      start_copy(32'h7F2C, 32'h7F34, 8'd4, 1'b0, 1'b0);
      while (!done && cyc < 100) begin
        if (bus_if.pr_we) begin
          nwr++;
          if (nwr < 4) begin
            bus_if.bus_gnt = 1'b0;
            for (int k = 0; k < 3; k++) begin
              tick(); cyc++;
              check("t2_wait_req", 32'(bus_if.bus_req), 1);
              check("t2_wait_we", 32'(bus_if.pr_we), 0);
            end
            bus_if.bus_gnt = 1'b1;
          end
        end
        tick(); cyc++;
      end
    end
    check("t2_done", 32'(done), 1);
    check("t2_cycles", 32'(cyc), 32'd19);
    check("t2_nwr", 32'(waddr.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_write("t2_w", i, 32'h7F34, 32'h1111_1111);
    tick();

    // Zero-length copy; also FIN coinciding with irq_ack.
    clear_log();
    start_copy(32'h7F2C, 32'h7F34, 8'd0, 1'b1, 1'b1);
    wait_done();
    check("t3_cycles", 32'(cyc), 32'd1);
    check("t3_irq_cleared", 32'(irq), 0);
    irq_ack = 1'b1;
    tick();
    check("t3_irq_set_wins", 32'(irq), 1);
    check("t3_req_seen", 32'(req_seen), 0);
    tick();
    check("t3_irq_ack", 32'(irq), 0);
    irq_ack = 1'b0;

    // Illegal source (misaligned) and illegal destination (above map).
    clear_log();
    start_copy(32'h7F3E, 32'h7F34, 8'd2, 1'b1, 1'b1);
    wait_done();
    check("t4a_cycles", 32'(cyc), 32'd2);
    check("t4a_err", 32'(err), 1);
    tick();
    start_copy(32'h7F2C, 32'h7F44, 8'd2, 1'b1, 1'b1);
    check("t4b_err_cleared", 32'(err), 0);
    wait_done();
    check("t4b_err", 32'(err), 1);
    check("t4_nwr", 32'(waddr.size()), 0);
    tick();

    // Destination walks off the top of the map after one word.
    clear_log();
    start_copy(32'h7F2C, 32'h7F40, 8'd3, 1'b1, 1'b1);
    wait_done();
    check("t5_cycles", 32'(cyc), 32'd4);
    check("t5_err", 32'(err), 1);
    check("t5_nwr", 32'(waddr.size()), 1);
    check_write("t5_w0", 0, 32'h7F40, 32'h1111_1111);
    tick();

    // Abort during read of word 2 of 5; start while busy ignored.
    clear_log();
    start_copy(32'h7F00, 32'h7F10, 8'd5, 1'b1, 1'b1);
    tick(); cyc++;                       // RD word 1
    src_addr = 32'h7F3E; start = 1'b1;
    tick(); cyc++;                       // WR word 1
    start = 1'b0;
    tick(); cyc++;                       // RD word 2
    abort = 1'b1;
    tick(); cyc++;                       // WR word 2
    abort = 1'b0;
    check("t6_we_word2", 32'(bus_if.pr_we), 1);
    wait_done();
    check("t6_cycles", 32'(cyc), 32'd6);
    check("t6_aborted", 32'(aborted), 1);
    check("t6_err", 32'(err), 0);
    check("t6_nwr", 32'(waddr.size()), 2);
    check_write("t6_w0", 0, 32'h7F10, 32'hA0A0_0001);
    check_write("t6_w1", 1, 32'h7F14, 32'hA0A0_0002);
    tick();

    // Reset asserted during a write.
    start_copy(32'h7F2C, 32'h7F38, 8'd3, 1'b1, 1'b1);
    tick(); tick();
    check("t7_in_wr", 32'(bus_if.pr_we), 1);
    rst_n = 1'b0;
    tick();
    check("t7_we", 32'(bus_if.pr_we), 0);
    check("t7_busy", 32'(busy), 0);
    check("t7_irq", 32'(irq), 0);
    check("t7_aborted", 32'(aborted), 0);
    check("t7_addr", bus_if.pr_addr, 0);
    rst_n = 1'b1;
    tick();
    check("t7_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pr_copy_master.md
Name: pr_copy_master

Overview:
- Bus initiator for the processor-side device bus (pr_addr/pr_we/pr_wd/pr_rd), i.e. the master end of the interface the device bridge responds to.
- Copies COUNT words from a source device address to a destination device address, one read-then-write pair per word. Typical uses: switch bank to LED, buffer to UART TX register.
- Shares the bus with the CPU through an external arbiter (bus_req/bus_gnt).
- Raises a level interrupt suitable for a spare HWInt line.

Parameters:
- COUNT_W, 8, width of word-count and remaining-count registers.
- MAP_LO, 32'h00007F00, lowest legal device byte address.
- MAP_HI, 32'h00007F43, highest legal device byte address.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  single-cycle command strobe.
- src_addr  in  32  first source byte address.
- dst_addr  in  32  first destination byte address.
- count  in  COUNT_W  number of words to copy.
- src_inc  in  1  when 1, source advances 4 per word; when 0, fixed source (FIFO-style register).
- dst_inc  in  1  when 1, destination advances 4 per word; when 0, fixed destination.
- abort  in  1  request early termination.
- irq_ack  in  1  clears irq.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error; cleared by accepted start.
- aborted  out  1  sticky abort flag; cleared by accepted start.
- irq  out  1  level interrupt.
- bus_req  out  1  bus request to arbiter.
- bus_gnt  in  1  bus grant from arbiter.
- pr_addr  out  32  bus byte address.
- pr_we  out  1  bus write enable.
- pr_wd  out  32  bus write data.
- pr_rd  in  32  bus read data, combinational from responder in the same cycle.

Behaviour:
- Reset (reset==0 at posedge): state IDLE; busy, done, err, aborted, irq, bus_req, pr_we = 0; pr_addr, pr_wd, data reg = 0; remaining = 0.
- All outputs are functions of state and registers only. There is no combinational path from any input to any output.
- States: IDLE, REQ, RD, WR, FIN.
- IDLE:
  - start accepted only here; start while busy is ignored.
  - On accept: latch src, dst, count, inc flags; clear err and aborted.
  - count==0 -> FIN; otherwise -> REQ.
- REQ:
  - bus_req=1.
  - If abort=1: set aborted, -> FIN.
  - Else if bus_gnt=1: range check, then -> RD. Range check fails when src or dst is outside [MAP_LO, MAP_HI-3] or addr[1:0]!=0; on failure set err and -> FIN with no bus access issued.
  - Else stay in REQ.
- RD (1 cycle): pr_addr=src, pr_we=0, bus_req=1. pr_rd is captured into the data reg at the clock edge. -> WR unconditionally.
- WR (1 cycle):
  - pr_addr=dst, pr_we=1, pr_wd=data reg, bus_req=1.
  - At the edge: src+=4 if src_inc; dst+=4 if dst_inc; remaining-=1.
  - Then, in priority order:
    - remaining was 1 -> FIN.
    - abort=1 -> set aborted, -> FIN.
    - bus_gnt=1 -> range check on the updated addresses; -> RD, or on failure set err and -> FIN.
    - otherwise -> REQ.
- The RD/WR pair is atomic:
  - The arbiter must not revoke bus_gnt while in RD or WR.
  - abort sampled in RD is not acted on in RD; it is honoured at the end of the following WR, with the word completed.
- FIN (1 cycle): bus_req=0, pr_we=0, done=1, irq<=1. -> IDLE.
- Bus idle value: pr_we=0 whenever not in WR; pr_addr and pr_wd hold their last values.
- irq:
  - Set on FIN.
  - Cleared by irq_ack or by accepted start.
  - If set and clear coincide, set wins.
- Throughput with gnt held: 2 cycles per word; first RD is 1 cycle after gnt is seen in REQ.
- Address arithmetic is 32-bit and wraps modulo 2^32. Wrapped addresses fail the range check (err).
- count = 2^COUNT_W-1 is legal.
- reset low mid-transfer: immediate return to reset values; the partial copy is not reported.

Decomposition:
- Shared package pr_bus_pkg holds:
  - state enum (IDLE, REQ, RD, WR, FIN);
  - MAP_LO and MAP_HI defaults;
  - WORD_BYTES = 4;
  - device base constants (TIMER 7F00, UART 7F10, SWITCH 7F2C, LED 7F34, TUBE 7F38, KEY 7F40).
- One combinational sub-module, pr_range_chk: inputs addr; output ok. Instantiated twice, once for src and once for dst.

Test Plan:
- count=3, src=7F2C inc, dst=7F38 inc, gnt tied 1, pr_rd = 11111111/22222222/33333333 -> writes to 7F38/7F3C/7F40 with that data; done after 8 cycles from start; irq=1; err=0.
- count=4, src=7F2C no-inc, dst=7F34 no-inc, gnt toggled low for 3 cycles between words -> 4 reads of 7F2C, 4 writes of 7F34; bus_req stays high while waiting; no access while gnt=0.
- count=0 -> done pulse one cycle after start; bus_req never asserted; irq=1.
- src=7F3E (misaligned) or dst=7F44 -> err=1, done pulse, pr_we never asserted. Separately, count=3 with dst=7F40 inc -> one word written to 7F40, then err on the second word at 7F44.
- abort during RD of word 2 of 5 -> word 2 write completes; done next; aborted=1; exactly 2 writes issued. Separately, start pulsed while busy -> ignored.
- reset=0 asserted during WR -> next cycle pr_we=0, busy=0, irq=0. irq_ack and FIN in the same cycle -> irq=1.
